phase_sweep_ctrl: RTL
=====================

PHASE_SWEEP_CTRL -- requirements
Module: phase_sweep_ctrl

Interface
REQ-001 Parameter REG_COUNT_LEN, default 64, width of BER error/bit counters.
REQ-002 Parameter WINDOW_LEN, default 1024, bits measured per phase.
REQ-003 Parameter SETTLE_CYCLES, default 32, clocks waited after a phase change before measuring.
REQ-004 Parameter TIMEOUT_CYCLES, default 65536, maximum clocks allowed per MEASURE.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 i_start  input  1  one-cycle pulse; begins a sweep when idle.
REQ-008 i_abort  input  1  level; aborts a sweep in progress.
REQ-009 i_error_count_r, i_error_count_i  input  REG_COUNT_LEN  BER error counts, I and Q rails.
REQ-010 i_bit_count_r  input  REG_COUNT_LEN  BER bit count, I rail; used as window progress.
REQ-011 o_phase  output  2  RX sampling phase driven to the DSP datapath.
REQ-012 o_enable_tx, o_enable_rx, o_enable_ber  output  1 each  datapath enables.
REQ-013 o_busy  output  1  high while a sweep runs.
REQ-014 o_done  output  1  one-cycle pulse on sweep completion.
REQ-015 o_timeout  output  1  sticky; high if any phase timed out in the last sweep.
REQ-016 o_best_phase  output  2  phase with the fewest errors in the last completed sweep.
REQ-017 o_best_errors  output  REG_COUNT_LEN+1  summed I+Q error count at o_best_phase.

Function
REQ-018 FSM states: IDLE, ENABLE, SETTLE, MEASURE, EVAL, NEXT, LOCK.
REQ-019 IDLE: o_busy=0; on i_start=1 go to ENABLE, set o_phase=0, clear o_timeout, set best_errors to all-ones.
REQ-020 i_start while o_busy=1 SHALL be ignored.
REQ-021 ENABLE: assert o_enable_tx and o_enable_rx (held high from here through LOCK and afterwards); next cycle go to SETTLE.
REQ-022 SETTLE: o_enable_ber=0; count SETTLE_CYCLES clocks, then go to MEASURE.
REQ-023 MEASURE: o_enable_ber=1; leave when i_bit_count_r >= WINDOW_LEN (go EVAL) or after TIMEOUT_CYCLES clocks (go EVAL with timeout flag).
REQ-024 EVAL (one cycle): sum = i_error_count_r + i_error_count_i, zero-extended to REG_COUNT_LEN+1 bits, with no overflow loss; a timed-out phase SHALL use an all-ones sum and set o_timeout.
REQ-025 EVAL: if sum < best_errors (strict less-than), update best_errors and best_phase; on a tie, keep the lower phase.
REQ-026 NEXT: deassert o_enable_ber; if o_phase==3 go to LOCK, else increment o_phase and go to SETTLE.
REQ-027 Every o_phase change SHALL be followed by a full SETTLE before o_enable_ber rises again.
REQ-028 LOCK (one cycle): drive o_phase=best_phase; load the o_best_phase and o_best_errors outputs; pulse o_done=1; go to IDLE.
REQ-029 o_best_phase and o_best_errors SHALL change only in LOCK; they hold their values between sweeps.
REQ-030 After LOCK, o_phase keeps best_phase; o_enable_ber=0 in IDLE.
REQ-031 i_abort=1 in any non-IDLE state: next state IDLE, o_enable_ber=0, o_done not pulsed, best outputs unchanged, o_phase holds its current value.
REQ-032 Simultaneous i_abort and the MEASURE window-complete condition: abort wins.
REQ-033 Sweep latency without timeouts: 1 + 4*(SETTLE_CYCLES + measure + 2) + 1 clocks from i_start to o_done.

Reset
REQ-034 On rst=1 (asynchronous), the FSM SHALL go to IDLE and all outputs SHALL clear: o_phase=0, all enables 0, o_busy=0, o_done=0, o_timeout=0, o_best_phase=0, o_best_errors=0.
REQ-035 The block SHALL leave reset synchronously on the first clk edge after rst falls.
REQ-036 Reset mid-sweep SHALL discard all partial results.

Verification
REQ-037 Error sums 40/3/3/90 for phases 0..3 -> o_best_phase=1 (tie with phase 2, lower phase kept), o_best_errors=3, one o_done pulse, o_phase=1 after sweep.
REQ-038 i_bit_count_r held at 0 for phase 2 -> that phase exits MEASURE after exactly TIMEOUT_CYCLES, o_timeout=1, phase 2 never selected.
REQ-039 Both error counts = 2^64-1 at every phase -> o_best_errors = 2^65-2 with no wraparound, o_best_phase=0.
REQ-040 i_abort pulsed during phase-1 SETTLE -> IDLE next cycle, o_done stays 0, previous best outputs unchanged; a second i_start then runs a full sweep.
REQ-041 rst asserted mid-MEASURE -> all outputs 0 immediately, without waiting for a clock edge; i_start pulsed while busy -> no restart and no change in state sequence.
REQ-042 Monitor check: o_enable_ber never rises within SETTLE_CYCLES clocks of any o_phase change.

Source files
------------

// File: rtl/phase_sweep_ctrl_if.sv
// Control/status bundle between the phase sweep controller and its host.
// The master side drives the start/abort controls and the BER counter
// readings. The slave side (the controller) drives the phase, the enables
// and the sweep results.
interface phase_sweep_ctrl_if #(
  parameter int REG_COUNT_LEN = 64
);
  logic                     i_start;
  logic                     i_abort;
  logic [REG_COUNT_LEN-1:0] i_error_count_r;
  logic [REG_COUNT_LEN-1:0] i_error_count_i;
  logic [REG_COUNT_LEN-1:0] i_bit_count_r;
  logic [1:0]               o_phase;
  logic                     o_enable_tx;
  logic                     o_enable_rx;
  logic                     o_enable_ber;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_timeout;
  logic [1:0]               o_best_phase;
  logic [REG_COUNT_LEN:0]   o_best_errors;

  modport master (
    output i_start, i_abort, i_error_count_r, i_error_count_i, i_bit_count_r,
    input  o_phase, o_enable_tx, o_enable_rx, o_enable_ber, o_busy, o_done,
           o_timeout, o_best_phase, o_best_errors
  );

  modport slave (
    input  i_start, i_abort, i_error_count_r, i_error_count_i, i_bit_count_r,
    output o_phase, o_enable_tx, o_enable_rx, o_enable_ber, o_busy, o_done,
           o_timeout, o_best_phase, o_best_errors
  );
endinterface

// File: rtl/phase_sweep_ctrl.sv
// RX sampling-phase sweep controller.
// The controller steps through phases 0..3. At each phase it waits a settle
// period, then measures BER over one window, or until a timeout expires.
// It keeps the phase with the fewest summed I+Q errors. When the sweep ends
// it locks o_phase to that best phase.
module phase_sweep_ctrl #(
  parameter int REG_COUNT_LEN  = 64,
  parameter int WINDOW_LEN     = 1024,
  parameter int SETTLE_CYCLES  = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  phase_sweep_ctrl_if.slave bus
);

  // One counter serves both the settle wait and the measure timeout.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]         SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]         TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REG_COUNT_LEN-1:0] WINDOW_VAL   = REG_COUNT_LEN'(WINDOW_LEN);
  localparam logic [REG_COUNT_LEN:0]   SUM_MAX      = '1;

  typedef enum logic [2:0] {
    IDLE, ENABLE, SETTLE, MEASURE, EVAL, NEXT, LOCK
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     timed_out;
  logic [1:0]               phase;
  logic [1:0]               best_phase;
  logic [REG_COUNT_LEN:0]   best_errors;
  logic [1:0]               best_phase_out;
  logic [REG_COUNT_LEN:0]   best_errors_out;
  logic                     enable_tx;
  logic                     enable_rx;
  logic                     enable_ber;
  logic                     busy;
  logic                     done;
  logic                     timeout;
  logic [REG_COUNT_LEN:0]   raw_sum;
  logic [REG_COUNT_LEN:0]   eval_sum;

  // The sum is one bit wider than the counters, so two full-scale counts
  // cannot wrap. A timed-out phase scores all-ones, so it can never beat a
  // real measurement.
  always_comb begin
    raw_sum  = {1'b0, bus.i_error_count_r} + {1'b0, bus.i_error_count_i};
    eval_sum = timed_out ? SUM_MAX : raw_sum;
  end

  // Sweep sequencer. All outputs are registered here, next to the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      timed_out       <= 1'b0;
      phase           <= 2'd0;
      best_phase      <= 2'd0;
      best_errors     <= '0;
      best_phase_out  <= 2'd0;
      best_errors_out <= '0;
      enable_tx       <= 1'b0;
      enable_rx       <= 1'b0;
      enable_ber      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && bus.i_abort) begin
        // Abort beats every other transition, including window complete.
        // o_phase and the published results are left as they are.
        state      <= IDLE;
        enable_ber <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_start) begin
              state       <= ENABLE;
              phase       <= 2'd0;
              timeout     <= 1'b0;
              best_errors <= SUM_MAX;
              best_phase  <= 2'd0;
              busy        <= 1'b1;
            end
          end
          ENABLE: begin
            enable_tx <= 1'b1;
            enable_rx <= 1'b1;
            cnt       <= '0;
            state     <= SETTLE;
          end
          SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt        <= '0;
              enable_ber <= 1'b1;
              state      <= MEASURE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          MEASURE: begin
            if (bus.i_bit_count_r >= WINDOW_VAL) begin
              timed_out <= 1'b0;
              state     <= EVAL;
            end else if (cnt == TIMEOUT_LAST) begin
              timed_out <= 1'b1;
              state     <= EVAL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          EVAL: begin
            if (timed_out) begin
              timeout <= 1'b1;
            end
            // Strict less-than. Phases arrive in ascending order, so on a
            // tie the lower phase is kept.
            if (eval_sum < best_errors) begin
              best_errors <= eval_sum;
              best_phase  <= phase;
            end
            enable_ber <= 1'b0;
            state      <= NEXT;
          end
          NEXT: begin
            if (phase == 2'd3) begin
              phase           <= best_phase;
              best_phase_out  <= best_phase;
              best_errors_out <= best_errors;
              done            <= 1'b1;
              state           <= LOCK;
            end else begin
              phase <= phase + 2'd1;
              cnt   <= '0;
              state <= SETTLE;
            end
          end
          LOCK: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_phase       = phase;
  assign bus.o_enable_tx   = enable_tx;
  assign bus.o_enable_rx   = enable_rx;
  assign bus.o_enable_ber  = enable_ber;
  assign bus.o_busy        = busy;
  assign bus.o_done        = done;
  assign bus.o_timeout     = timeout;
  assign bus.o_best_phase  = best_phase_out;
  assign bus.o_best_errors = best_errors_out;

endmodule
